// File: rtl/sum_serial_nb_if.sv
// rtl/sum_serial_nb_if.sv - start/busy/done operand and result bundle for sum_serial_nb
interface sum_serial_nb_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             Sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output start, A, B, Ci, Sub,
        input  busy, done, Sum, Cout, Ovf
    );

    modport slave (
        input  start, A, B, Ci, Sub,
        output busy, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/sum_serial_nb.sv
// rtl/sum_serial_nb.sv - digit-serial adder/subtractor, DIGIT bits per clock
module sum_serial_nb #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    sum_serial_nb_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;
    logic             c_msb;
    logic             last_digit;
    logic             accept;
    logic             busy_c;
    logic             done_c;

    // One DIGIT-bit ripple slice; the carry into its top bit recovers the carry into the MSB.
    always_comb begin
        dsum       = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        c_msb      = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dsum[DIGIT-1];
        res_next   = WIDTH'({dsum[DIGIT-1:0], res_sr} >> DIGIT);
        last_digit = (cnt == CW'(N - 1));
        accept     = ((state == IDLE) || (state == DONE)) && bus.start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_digit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = bus.start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Subtraction is A + ~B + ~Ci, so B and Ci are inverted once at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.A;
            b_sr  <= bus.B ^ {WIDTH{bus.Sub}};
            carry <= bus.Ci ^ bus.Sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            carry  <= dsum[DIGIT];
            res_sr <= res_next;
            cnt    <= cnt + 1'b1;
            if (last_digit) begin
                sum_q  <= res_next;
                cout_q <= dsum[DIGIT];
                ovf_q  <= c_msb ^ dsum[DIGIT];
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;
endmodule

// File: tb/tb_sum_serial_nb.sv
// tb/tb_sum_serial_nb.sv - directed vectors, handshake/reset sequences and width sweep for sum_serial_nb
module tb_sum_serial_nb;
    logic clk = 1'b0;
    logic rst;
    logic sw_rst;
    int   errors = 0;
    int   checks = 0;
    bit   sw_done [4];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    sum_serial_nb_if #(.WIDTH(16)) m ();
    sum_serial_nb #(.WIDTH(16), .DIGIT(4)) dut (.clk(clk), .rst(rst), .bus(m.slave));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    // Called at posedge+#1 with the DUT in IDLE or DONE; returns with done visible.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sub, output int lat, output bit hs_ok);
        m.A = a; m.B = b; m.Ci = ci; m.Sub = sub; m.start = 1'b1;
        @(posedge clk); #1;
        m.start = 1'b0;
        lat = 0;
        hs_ok = 1'b1;
        while (!m.done && lat < 50) begin
            if (!m.busy) hs_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (m.busy) hs_ok = 1'b0;
    endtask

    initial begin
        vec_t vecs [10];
        int   lat;
        bit   hs_ok;
        int   ndone;
        int   k;
        int   exp_cyc [3];

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        rst = 1'b1; sw_rst = 1'b1;
        m.start = 1'b0; m.A = '0; m.B = '0; m.Ci = 1'b0; m.Sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(m.busy), 64'd0);
        check("rst_done", 64'(m.done), 64'd0);
        check("rst_sum", 64'(m.Sum), 64'd0);
        check("rst_cout", 64'(m.Cout), 64'd0);
        check("rst_ovf", 64'(m.Ovf), 64'd0);
        rst = 1'b0; sw_rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, lat, hs_ok);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d_busy", i), 64'(hs_ok), 64'd1);
            check($sformatf("vec%0d_sum", i), 64'(m.Sum), 64'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 64'(m.Cout), 64'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i), 64'(m.Ovf), 64'(vecs[i].ovf));
        end
        @(posedge clk); #1;

        // start pulsed during RUN must be dropped, not queued
        m.A = 16'h0003; m.B = 16'h0004; m.Ci = 1'b0; m.Sub = 1'b0; m.start = 1'b1;
        @(posedge clk); #1;
        m.start = 1'b0;
        @(posedge clk); #1;
        m.A = 16'h1111; m.B = 16'h1111; m.start = 1'b1;
        ndone = 0;
        @(posedge clk); #1;
        m.start = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (m.done) ndone++;
            @(posedge clk); #1;
        end
        check("run_start_ignored_dones", 64'(ndone), 64'd1);
        check("run_start_ignored_sum", 64'(m.Sum), 64'h0007);

        // start held high: done at 4, 9, 14 cycles after the first start edge
        exp_cyc[0] = 4; exp_cyc[1] = 9; exp_cyc[2] = 14;
        k = 0;
        m.A = 16'h0001; m.B = 16'h0001; m.start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (m.busy && m.done) check("held_busy_and_done", 64'd1, 64'd0);
            if (m.done) begin
                if (k < 3) begin
                    check($sformatf("held_done%0d_cycle", k), 64'(c), 64'(exp_cyc[k]));
                    check($sformatf("held_done%0d_sum", k), 64'(m.Sum), 64'(2 * (k + 1)));
                end
                k++;
                m.A = 16'(k + 1); m.B = 16'(k + 1);
            end
        end
        check("held_done_count", 64'(k), 64'd3);
        m.start = 1'b0;
        @(posedge clk); #1;

        // reset on the second RUN cycle
        m.A = 16'h1234; m.B = 16'h1111; m.start = 1'b1;
        @(posedge clk); #1;
        m.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 64'(m.busy), 64'd0);
        check("midrst_done", 64'(m.done), 64'd0);
        check("midrst_sum", 64'(m.Sum), 64'd0);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (m.done) ndone++;
            @(posedge clk); #1;
        end
        check("midrst_no_done", 64'(ndone), 64'd0);
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat, hs_ok);
        check("postrst_latency", 64'(lat), 64'd4);
        check("postrst_sum", 64'(m.Sum), 64'h2345);
        check("postrst_cout", 64'(m.Cout), 64'd0);

        for (int t = 0; t < 60000 && !(sw_done[0] && sw_done[1] && sw_done[2] && sw_done[3]); t++)
            @(posedge clk);
        for (int g = 0; g < 4; g++)
            check($sformatf("sweep%0d_complete", g), 64'(sw_done[g]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    for (genvar g = 0; g < 4; g++) begin : sw
        localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 32 : 64;
        localparam int D = (g == 0) ? 1 : (g == 1) ? 16 : (g == 2) ? 8 : 4;

        sum_serial_nb_if #(.WIDTH(W)) s ();
        sum_serial_nb #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst(sw_rst), .bus(s.slave));

        initial begin
            logic [W-1:0] a, b, bx, es;
            logic [W:0]   full;
            logic         ci, sub, cin, ec, eo, cim;
            int           lat;

            s.start = 1'b0; s.A = '0; s.B = '0; s.Ci = 1'b0; s.Sub = 1'b0;
            sw_done[g] = 1'b0;
            @(posedge clk);
            while (sw_rst) @(posedge clk);
            #1;
            for (int i = 0; i < 1000; i++) begin
                a   = W'({$urandom(), $urandom()});
                b   = W'({$urandom(), $urandom()});
                ci  = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
                bx   = sub ? ~b : b;
                cin  = ci ^ sub;
                full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
                es   = full[W-1:0];
                ec   = full[W];
                cim  = a[W-1] ^ bx[W-1] ^ es[W-1];
                eo   = cim ^ ec;

                s.A = a; s.B = b; s.Ci = ci; s.Sub = sub; s.start = 1'b1;
                @(posedge clk); #1;
                s.start = 1'b0;
                lat = 0;
                while (!s.done && lat < 200) begin
                    @(posedge clk); #1;
                    lat++;
                end
                check($sformatf("sw%0d_%0d_latency", g, i), 64'(lat), 64'(W / D));
                check($sformatf("sw%0d_%0d_sum", g, i), 64'(s.Sum), 64'(es));
                check($sformatf("sw%0d_%0d_cout", g, i), 64'(s.Cout), 64'(ec));
                check($sformatf("sw%0d_%0d_ovf", g, i), 64'(s.Ovf), 64'(eo));
            end
            sw_done[g] = 1'b1;
        end
    end
endmodule
